// File: rtl/bp_io_link_to_lce_buffered.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bp_io_link_to_lce_buffered: buffered multi-outstanding I/O link <-> LCE UC bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
module bp_io_link_to_lce_buffered #(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 64,
  parameter int lce_id_width_p    = 4,
  parameter int cce_id_width_p    = 4,
  parameter int num_cce_p         = 1,
  parameter int block_offset_p    = 6,
  parameter int cmd_fifo_els_p    = 2,
  parameter int max_outstanding_p = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [lce_id_width_p-1:0]              lce_id_i,

  input  logic                                   io_cmd_v_i,
  output logic                                   io_cmd_ready_o,
  input  logic                                   io_cmd_wr_not_rd_i,
  input  logic [paddr_width_p-1:0]               io_cmd_addr_i,
  input  logic [2:0]                             io_cmd_size_i,
  input  logic [data_width_p-1:0]                io_cmd_data_i,

  output logic                                   lce_req_v_o,
  input  logic                                   lce_req_ready_i,
  output logic                                   lce_req_wr_not_rd_o,
  output logic [paddr_width_p-1:0]               lce_req_addr_o,
  output logic [2:0]                             lce_req_size_o,
  output logic [data_width_p-1:0]                lce_req_data_o,
  output logic [lce_id_width_p-1:0]              lce_req_src_id_o,
  output logic [cce_id_width_p-1:0]              lce_req_dst_id_o,

  input  logic                                   lce_cmd_v_i,
  output logic                                   lce_cmd_yumi_o,
  input  logic                                   lce_cmd_uc_done_i,
  input  logic [paddr_width_p-1:0]               lce_cmd_addr_i,
  input  logic [data_width_p-1:0]                lce_cmd_data_i,

  output logic                                   io_resp_v_o,
  input  logic                                   io_resp_ready_i,
  output logic                                   io_resp_wr_not_rd_o,
  output logic [paddr_width_p-1:0]               io_resp_addr_o,
  output logic [2:0]                             io_resp_size_o,
  output logic [data_width_p-1:0]                io_resp_data_o,

  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                   error_o
);

  localparam int out_width_lp = $clog2(max_outstanding_p + 1);
  localparam int cmd_cnt_width_lp = $clog2(cmd_fifo_els_p + 1);
  localparam int cmd_ptr_width_lp = (cmd_fifo_els_p > 1) ? $clog2(cmd_fifo_els_p) : 1;
  localparam int trk_ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  // Command FIFO storage
  logic                     cmd_wr_mem   [cmd_fifo_els_p];
  logic [paddr_width_p-1:0] cmd_addr_mem [cmd_fifo_els_p];
  logic [2:0]               cmd_size_mem [cmd_fifo_els_p];
  logic [data_width_p-1:0]  cmd_data_mem [cmd_fifo_els_p];
  logic [cmd_ptr_width_lp-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [cmd_cnt_width_lp-1:0] cmd_count;

  // Tracker FIFO storage; its occupancy is the outstanding count
  logic                     trk_wr_mem   [max_outstanding_p];
  logic [paddr_width_p-1:0] trk_addr_mem [max_outstanding_p];
  logic [2:0]               trk_size_mem [max_outstanding_p];
  logic [trk_ptr_width_lp-1:0] trk_wr_ptr, trk_rd_ptr;
  logic [out_width_lp-1:0]     outstanding;

  logic                     resp_v;
  logic                     resp_wr;
  logic [paddr_width_p-1:0] resp_addr;
  logic [2:0]               resp_size;
  logic [data_width_p-1:0]  resp_data;
  logic                     error;
  logic                     live;

  logic                      cmd_full, cmd_empty, cmd_enq, credit_avail, req_fire;
  logic                      trk_pop, orphan, mismatch;
  logic                      head_wr, trk_head_wr;
  logic [paddr_width_p-1:0]  head_addr, trk_head_addr;
  logic [2:0]                head_size, trk_head_size;
  logic [data_width_p-1:0]   head_data;
  logic [cce_id_width_p-1:0] head_dst;

  function automatic logic [cmd_ptr_width_lp-1:0] cmd_ptr_next(input logic [cmd_ptr_width_lp-1:0] p);
    return (p == cmd_ptr_width_lp'(cmd_fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [trk_ptr_width_lp-1:0] trk_ptr_next(input logic [trk_ptr_width_lp-1:0] p);
    return (p == trk_ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_wr   = cmd_wr_mem[cmd_rd_ptr];
  assign head_addr = cmd_addr_mem[cmd_rd_ptr];
  assign head_size = cmd_size_mem[cmd_rd_ptr];
  assign head_data = cmd_data_mem[cmd_rd_ptr];

  assign trk_head_wr   = trk_wr_mem[trk_rd_ptr];
  assign trk_head_addr = trk_addr_mem[trk_rd_ptr];
  assign trk_head_size = trk_size_mem[trk_rd_ptr];

  generate
    if (num_cce_p == 1) begin : g_single_cce
      assign head_dst = '0;
    end else begin : g_striped_cce
      localparam int cce_bits_lp = $clog2(num_cce_p);
      assign head_dst = cce_id_width_p'(head_addr[block_offset_p +: cce_bits_lp]);
    end
  endgenerate

  // live gates the combinational handshakes so they stay low through reset
  assign cmd_full       = (cmd_count == cmd_cnt_width_lp'(cmd_fifo_els_p));
  assign cmd_empty      = (cmd_count == '0);
  assign io_cmd_ready_o = live & ~cmd_full;
  assign cmd_enq        = io_cmd_v_i & io_cmd_ready_o;
  assign credit_avail   = (outstanding < out_width_lp'(max_outstanding_p));
  assign lce_req_v_o    = ~cmd_empty & credit_avail;
  assign req_fire       = lce_req_v_o & lce_req_ready_i;

  assign lce_req_wr_not_rd_o = lce_req_v_o & head_wr;
  assign lce_req_addr_o      = lce_req_v_o ? head_addr : '0;
  assign lce_req_size_o      = lce_req_v_o ? head_size : '0;
  assign lce_req_data_o      = lce_req_v_o ? head_data : '0;
  assign lce_req_src_id_o    = lce_req_v_o ? lce_id_i  : '0;
  assign lce_req_dst_id_o    = lce_req_v_o ? head_dst  : '0;

  assign lce_cmd_yumi_o = live & lce_cmd_v_i & (~resp_v | io_resp_ready_i);
  assign trk_pop        = lce_cmd_yumi_o & (outstanding != '0);
  assign orphan         = lce_cmd_yumi_o & (outstanding == '0);
  assign mismatch       = trk_pop & ((lce_cmd_uc_done_i != trk_head_wr) |
                                     (lce_cmd_addr_i != trk_head_addr));

  always_ff @(posedge clk_i) begin
    if (cmd_enq) begin
      cmd_wr_mem[cmd_wr_ptr]   <= io_cmd_wr_not_rd_i;
      cmd_addr_mem[cmd_wr_ptr] <= io_cmd_addr_i;
      cmd_size_mem[cmd_wr_ptr] <= io_cmd_size_i;
      cmd_data_mem[cmd_wr_ptr] <= io_cmd_data_i;
    end
    if (req_fire) begin
      trk_wr_mem[trk_wr_ptr]   <= head_wr;
      trk_addr_mem[trk_wr_ptr] <= head_addr;
      trk_size_mem[trk_wr_ptr] <= head_size;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live        <= 1'b0;
      cmd_wr_ptr  <= '0;
      cmd_rd_ptr  <= '0;
      cmd_count   <= '0;
      trk_wr_ptr  <= '0;
      trk_rd_ptr  <= '0;
      outstanding <= '0;
      error       <= 1'b0;
    end else begin
      live <= 1'b1;
      if (cmd_enq)  cmd_wr_ptr <= cmd_ptr_next(cmd_wr_ptr);
      if (req_fire) cmd_rd_ptr <= cmd_ptr_next(cmd_rd_ptr);
      case ({cmd_enq, req_fire})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
      if (req_fire) trk_wr_ptr <= trk_ptr_next(trk_wr_ptr);
      if (trk_pop)  trk_rd_ptr <= trk_ptr_next(trk_rd_ptr);
      case ({req_fire, trk_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (orphan | mismatch) error <= 1'b1;
    end
  end

  // The response is always built from the tracker, even when the completion disagrees
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v    <= 1'b0;
      resp_wr   <= 1'b0;
      resp_addr <= '0;
      resp_size <= '0;
      resp_data <= '0;
    end else if (trk_pop) begin
      resp_v    <= 1'b1;
      resp_wr   <= trk_head_wr;
      resp_addr <= trk_head_addr;
      resp_size <= trk_head_size;
      resp_data <= trk_head_wr ? '0 : lce_cmd_data_i;
    end else if (io_resp_ready_i) begin
      resp_v <= 1'b0;
    end
  end

  assign io_resp_v_o         = resp_v;
  assign io_resp_wr_not_rd_o = resp_wr;
  assign io_resp_addr_o      = resp_addr;
  assign io_resp_size_o      = resp_size;
  assign io_resp_data_o      = resp_data;
  assign outstanding_o       = outstanding;
  assign error_o             = error;

endmodule
`default_nettype wire

// File: tb/tb_bp_io_link_to_lce_buffered.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bp_io_link_to_lce_buffered: directed + randomized check against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bp_io_link_to_lce_buffered;

  localparam int PA = 40;
  localparam int DW = 64;
  localparam int CMD_ELS = 2;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic          wr;
    logic [PA-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] lce_id = 4'd5;
  logic io_cmd_v = 1'b0, io_cmd_ready, io_cmd_wr = 1'b0;
  logic [PA-1:0] io_cmd_addr = '0;
  logic [2:0] io_cmd_size = '0;
  logic [DW-1:0] io_cmd_data = '0;
  logic lce_req_v, lce_req_ready = 1'b0, lce_req_wr;
  logic [PA-1:0] lce_req_addr;
  logic [2:0] lce_req_size;
  logic [DW-1:0] lce_req_data;
  logic [3:0] lce_req_src, lce_req_dst;
  logic lce_cmd_v = 1'b0, lce_cmd_yumi, lce_cmd_uc_done = 1'b0;
  logic [PA-1:0] lce_cmd_addr = '0;
  logic [DW-1:0] lce_cmd_data = '0;
  logic io_resp_v, io_resp_ready = 1'b0, io_resp_wr;
  logic [PA-1:0] io_resp_addr;
  logic [2:0] io_resp_size;
  logic [DW-1:0] io_resp_data;
  logic [2:0] outstanding;
  logic error;

  // second instance, four CCEs, used for address striping only
  logic b_cmd_v = 1'b0, b_cmd_ready, b_req_v, b_req_ready = 1'b0, b_req_wr;
  logic [PA-1:0] b_cmd_addr = '0, b_req_addr, b_resp_addr;
  logic [2:0] b_req_size, b_resp_size, b_out;
  logic [DW-1:0] b_req_data, b_resp_data;
  logic [3:0] b_req_src, b_req_dst;
  logic b_yumi, b_resp_v, b_resp_wr, b_error;

  always #5 clk = ~clk;

  bp_io_link_to_lce_buffered dut (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
    .io_cmd_v_i(io_cmd_v), .io_cmd_ready_o(io_cmd_ready), .io_cmd_wr_not_rd_i(io_cmd_wr),
    .io_cmd_addr_i(io_cmd_addr), .io_cmd_size_i(io_cmd_size), .io_cmd_data_i(io_cmd_data),
    .lce_req_v_o(lce_req_v), .lce_req_ready_i(lce_req_ready), .lce_req_wr_not_rd_o(lce_req_wr),
    .lce_req_addr_o(lce_req_addr), .lce_req_size_o(lce_req_size), .lce_req_data_o(lce_req_data),
    .lce_req_src_id_o(lce_req_src), .lce_req_dst_id_o(lce_req_dst),
    .lce_cmd_v_i(lce_cmd_v), .lce_cmd_yumi_o(lce_cmd_yumi), .lce_cmd_uc_done_i(lce_cmd_uc_done),
    .lce_cmd_addr_i(lce_cmd_addr), .lce_cmd_data_i(lce_cmd_data),
    .io_resp_v_o(io_resp_v), .io_resp_ready_i(io_resp_ready), .io_resp_wr_not_rd_o(io_resp_wr),
    .io_resp_addr_o(io_resp_addr), .io_resp_size_o(io_resp_size), .io_resp_data_o(io_resp_data),
    .outstanding_o(outstanding), .error_o(error)
  );

  bp_io_link_to_lce_buffered #(.num_cce_p(4), .block_offset_p(6)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
    .io_cmd_v_i(b_cmd_v), .io_cmd_ready_o(b_cmd_ready), .io_cmd_wr_not_rd_i(1'b0),
    .io_cmd_addr_i(b_cmd_addr), .io_cmd_size_i(3'd3), .io_cmd_data_i(64'd0),
    .lce_req_v_o(b_req_v), .lce_req_ready_i(b_req_ready), .lce_req_wr_not_rd_o(b_req_wr),
    .lce_req_addr_o(b_req_addr), .lce_req_size_o(b_req_size), .lce_req_data_o(b_req_data),
    .lce_req_src_id_o(b_req_src), .lce_req_dst_id_o(b_req_dst),
    .lce_cmd_v_i(1'b0), .lce_cmd_yumi_o(b_yumi), .lce_cmd_uc_done_i(1'b0),
    .lce_cmd_addr_i(40'd0), .lce_cmd_data_i(64'd0),
    .io_resp_v_o(b_resp_v), .io_resp_ready_i(1'b1), .io_resp_wr_not_rd_o(b_resp_wr),
    .io_resp_addr_o(b_resp_addr), .io_resp_size_o(b_resp_size), .io_resp_data_o(b_resp_data),
    .outstanding_o(b_out), .error_o(b_error)
  );

  int checks = 0;
  int failures = 0;

  // reference model: pending commands, in-flight requests, pending response, error flag
  txn_t cq[$];
  txn_t tq[$];
  txn_t m_rsp;
  logic m_rv = 1'b0;
  logic m_err = 1'b0;
  logic last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PA-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[PA-1:0];
  endfunction

  // One clock: check outputs at the falling edge, advance the model, return 1ns past the rising edge
  task automatic cyc();
    logic exp_ready, exp_req_v, exp_yumi;
    txn_t t, n;
    @(negedge clk);
    exp_ready = (cq.size() < CMD_ELS);
    exp_req_v = (cq.size() > 0) && (tq.size() < MAX_OUT);
    exp_yumi  = lce_cmd_v && (!m_rv || io_resp_ready);
    chk("io_cmd_ready", io_cmd_ready, exp_ready);
    chk("lce_req_v", lce_req_v, exp_req_v);
    if (exp_req_v) begin
      chk("req_wr", lce_req_wr, cq[0].wr);
      chk("req_addr", lce_req_addr, cq[0].addr);
      chk("req_size", lce_req_size, cq[0].size);
      chk("req_data", lce_req_data, cq[0].data);
      chk("req_src", lce_req_src, lce_id);
      chk("req_dst", lce_req_dst, 0);
    end
    chk("lce_cmd_yumi", lce_cmd_yumi, exp_yumi);
    chk("io_resp_v", io_resp_v, m_rv);
    if (m_rv) begin
      chk("resp_wr", io_resp_wr, m_rsp.wr);
      chk("resp_addr", io_resp_addr, m_rsp.addr);
      chk("resp_size", io_resp_size, m_rsp.size);
      chk("resp_data", io_resp_data, m_rsp.data);
    end
    chk("outstanding", outstanding, tq.size());
    chk("error", error, m_err);

    last_acc = io_cmd_v && exp_ready;
    if (exp_yumi && tq.size() > 0) begin
      t = tq.pop_front();
      if (lce_cmd_uc_done != t.wr || lce_cmd_addr != t.addr) m_err = 1'b1;
      m_rsp = t;
      m_rsp.data = t.wr ? '0 : lce_cmd_data;
      m_rv = 1'b1;
    end else begin
      if (exp_yumi) m_err = 1'b1;
      if (io_resp_ready) m_rv = 1'b0;
    end
    if (exp_req_v && lce_req_ready) tq.push_back(cq.pop_front());
    if (last_acc) begin
      n.wr = io_cmd_wr; n.addr = io_cmd_addr; n.size = io_cmd_size; n.data = io_cmd_data;
      cq.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  // Drive a well-formed completion for the oldest in-flight request (if any)
  task automatic drive_ret(input logic on, input logic [DW-1:0] data);
    lce_cmd_v = on && (tq.size() > 0);
    if (tq.size() > 0) begin
      lce_cmd_uc_done = tq[0].wr;
      lce_cmd_addr    = tq[0].addr;
    end
    lce_cmd_data = data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    io_cmd_v = 1'b0; lce_cmd_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cq.delete(); tq.delete(); m_rv = 1'b0; m_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [PA-1:0] x;
    logic [DW-1:0] da, db;
    int n;

    // Reset: handshakes stay low even with valid inputs asserted
    #3;
    io_cmd_v = 1'b1; lce_cmd_v = 1'b1;
    #10;
    chk("rst_io_cmd_ready", io_cmd_ready, 0);
    chk("rst_lce_req_v", lce_req_v, 0);
    chk("rst_yumi", lce_cmd_yumi, 0);
    chk("rst_resp_v", io_resp_v, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_error", error, 0);
    io_cmd_v = 1'b0; lce_cmd_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", io_cmd_ready, 1);

    // Single read
    io_cmd_v = 1'b1; io_cmd_wr = 1'b0; io_cmd_addr = 40'h80000040; io_cmd_size = 3'd3;
    io_cmd_data = {$urandom, $urandom};
    cyc();
    io_cmd_v = 1'b0;
    chk("rd_req_v", lce_req_v, 1);
    chk("rd_req_wr", lce_req_wr, 0);
    chk("rd_req_addr", lce_req_addr, 40'h80000040);
    chk("rd_req_src", lce_req_src, 5);
    chk("rd_req_dst", lce_req_dst, 0);
    lce_req_ready = 1'b1;
    cyc();
    lce_req_ready = 1'b0;
    chk("rd_outstanding", outstanding, 1);
    lce_cmd_v = 1'b1; lce_cmd_uc_done = 1'b0; lce_cmd_addr = 40'h80000040;
    lce_cmd_data = 64'hDEADBEEF01234567;
    #1;
    chk("rd_yumi", lce_cmd_yumi, 1);
    cyc();
    lce_cmd_v = 1'b0;
    chk("rd_resp_v", io_resp_v, 1);
    chk("rd_resp_wr", io_resp_wr, 0);
    chk("rd_resp_addr", io_resp_addr, 40'h80000040);
    chk("rd_resp_size", io_resp_size, 3);
    chk("rd_resp_data", io_resp_data, 64'hDEADBEEF01234567);
    io_resp_ready = 1'b1;
    cyc();
    chk("rd_resp_drained", io_resp_v, 0);

    // Credit limit: six writes, no completions
    lce_req_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 6; i++) begin
      io_cmd_v = 1'b1; io_cmd_wr = 1'b1; io_cmd_addr = rand_addr();
      io_cmd_size = 3'($urandom_range(0, 3)); io_cmd_data = {$urandom, $urandom};
      cyc();
      if (last_acc) n++;
    end
    io_cmd_v = 1'b0;
    chk("credit_accepted", n, 6);
    repeat (3) cyc();
    chk("credit_outstanding", outstanding, 4);
    chk("credit_req_v", lce_req_v, 0);
    chk("credit_fifo_full", io_cmd_ready, 0);
    drive_ret(1'b1, {$urandom, $urandom});
    cyc();
    drive_ret(1'b0, '0);
    chk("credit_freed", outstanding, 3);
    chk("credit_fifth_req_v", lce_req_v, 1);
    // issue of the fifth and a return in the same cycle
    drive_ret(1'b1, {$urandom, $urandom});
    cyc();
    drive_ret(1'b0, '0);
    chk("concurrent_outstanding", outstanding, 3);
    cyc();
    chk("sixth_issued", outstanding, 4);
    for (int i = 0; i < 20 && tq.size() > 0; i++) begin
      drive_ret(1'b1, {$urandom, $urandom});
      cyc();
    end
    drive_ret(1'b0, '0);
    cyc();

    // Back-pressure on the response side
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      io_cmd_v = 1'b1; io_cmd_wr = 1'b0; io_cmd_addr = rand_addr(); io_cmd_size = 3'd2;
      cyc();
      if (last_acc) n++;
    end
    io_cmd_v = 1'b0;
    for (int i = 0; i < 10 && tq.size() < 2; i++) cyc();
    chk("bp_two_pending", outstanding, 2);
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    io_resp_ready = 1'b0;
    drive_ret(1'b1, da);
    #1;
    chk("bp_first_yumi", lce_cmd_yumi, 1);
    cyc();
    drive_ret(1'b1, db);
    #1;
    chk("bp_second_blocked", lce_cmd_yumi, 0);
    cyc();
    chk("bp_hold_data", io_resp_data, da);
    cyc();
    chk("bp_hold_data2", io_resp_data, da);
    io_resp_ready = 1'b1;
    #1;
    chk("bp_release_yumi", lce_cmd_yumi, 1);
    cyc();
    drive_ret(1'b0, '0);
    chk("bp_second_data", io_resp_data, db);
    cyc();
    chk("bp_drained", io_resp_v, 0);

    // Orphan completion
    lce_cmd_v = 1'b1; lce_cmd_uc_done = 1'b0; lce_cmd_addr = rand_addr();
    #1;
    chk("orphan_yumi", lce_cmd_yumi, 1);
    cyc();
    lce_cmd_v = 1'b0;
    chk("orphan_no_resp", io_resp_v, 0);
    chk("orphan_error", error, 1);
    cyc();

    // Reset mid-stream drops everything asynchronously
    for (int i = 0; i < 3; i++) begin
      io_cmd_v = 1'b1; io_cmd_wr = 1'b0; io_cmd_addr = rand_addr(); cyc();
    end
    lce_cmd_v = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", io_cmd_ready, 0);
    chk("mid_rst_req_v", lce_req_v, 0);
    chk("mid_rst_req_addr", lce_req_addr, 0);
    chk("mid_rst_yumi", lce_cmd_yumi, 0);
    chk("mid_rst_resp_v", io_resp_v, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_error", error, 0);
    do_reset();

    // Completion type disagrees with the tracked read
    x = rand_addr();
    io_cmd_v = 1'b1; io_cmd_wr = 1'b0; io_cmd_addr = x; io_cmd_size = 3'd1;
    cyc();
    io_cmd_v = 1'b0;
    cyc();
    da = {$urandom, $urandom};
    lce_cmd_v = 1'b1; lce_cmd_uc_done = 1'b1; lce_cmd_addr = x; lce_cmd_data = da;
    cyc();
    lce_cmd_v = 1'b0;
    chk("mm_error", error, 1);
    chk("mm_resp_is_read", io_resp_wr, 0);
    chk("mm_resp_data", io_resp_data, da);
    cyc();
    do_reset();

    // Randomized traffic with well-formed completions
    for (int i = 0; i < 400; i++) begin
      io_cmd_v = 1'($urandom); io_cmd_wr = 1'($urandom); io_cmd_addr = rand_addr();
      io_cmd_size = 3'($urandom); io_cmd_data = {$urandom, $urandom};
      lce_req_ready = 1'($urandom);
      io_resp_ready = ($urandom_range(0, 3) != 0);
      drive_ret(1'($urandom), {$urandom, $urandom});
      cyc();
    end
    io_cmd_v = 1'b0; lce_req_ready = 1'b1; io_resp_ready = 1'b1;
    for (int i = 0; i < 100 && (cq.size() > 0 || tq.size() > 0 || m_rv); i++) begin
      drive_ret(1'b1, {$urandom, $urandom});
      cyc();
    end
    drive_ret(1'b0, '0);
    cyc();
    chk("rand_idle_outstanding", outstanding, 0);
    chk("rand_no_error", error, 0);

    // Striping on the four-CCE instance
    b_cmd_v = 1'b1; b_cmd_addr = 40'h0C0;
    @(posedge clk); #1;
    b_cmd_addr = 40'h100;
    @(posedge clk); #1;
    b_cmd_v = 1'b0;
    chk("stripe_v", b_req_v, 1);
    chk("stripe_dst_0c0", b_req_dst, 3);
    b_req_ready = 1'b1;
    @(posedge clk); #1;
    b_req_ready = 1'b0;
    chk("stripe_dst_100", b_req_dst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
